// File: rtl/mips_mon_pkg.sv
// Shared types for the MIPS run monitor: controller states and a constant-safe clog2.
// Consumed by mips_run_monitor; no logic of its own.
package mips_mon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } mon_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/mon_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// One-cycle update, holds at all-ones instead of wrapping; never stalls.
module mon_sat_counter #(
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            inc,
   output logic [CNTW-1:0] q
);

   localparam logic [CNTW-1:0] ONE = CNTW'(1);

   logic [CNTW-1:0] cnt_d;
   logic [CNTW-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign q = cnt_q;

endmodule

// File: rtl/mips_run_monitor.sv
// Round-robin register-file checker with timeout plus a non-zero push counter for the MIPS top.
// Verdict lands NCHK edges after the start edge at best, TIMEOUT at worst; no backpressure.
module mips_run_monitor
   import mips_mon_pkg::*;
#(
   parameter int DW      = 32,
   parameter int SELW    = 5,
   parameter int NCHK    = 4,
   parameter int TIMEOUT = 1000,
   parameter int CNTW    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NCHK*SELW-1:0] exp_sel,
   input  logic [NCHK*DW-1:0]   exp_val,
   input  logic                 memwrite,
   input  logic [DW-1:0]        writedata,
   output logic [SELW-1:0]      dispSel,
   input  logic [DW-1:0]        dispDat,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [NCHK-1:0]      fail_mask,
   output logic [CNTW-1:0]      push_cnt,
   output logic [DW-1:0]        last_push
);

   localparam int PW  = (NCHK > 1) ? clog2(NCHK) : 1;
   // Cycle counter is widened when needed so TIMEOUT-1 is always reachable.
   localparam int CYW = (clog2(TIMEOUT) > CNTW) ? clog2(TIMEOUT) : CNTW;
   localparam logic [CYW-1:0] CYC_LAST = CYW'(TIMEOUT - 1);
   localparam logic [PW-1:0]  PTR_LAST = PW'(NCHK - 1);
   localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

   mon_state_e      state_d, state_q;
   logic [PW-1:0]   ptr_d, ptr_q;
   logic [NCHK-1:0] match_d, match_q;
   logic [NCHK-1:0] fail_mask_d, fail_mask_q;
   logic [DW-1:0]   last_push_d, last_push_q;

   logic [SELW-1:0] sel_cur;
   logic [DW-1:0]   val_cur;
   logic [NCHK-1:0] match_upd;
   logic            hit;
   logic            run_clr;
   logic            cyc_inc;
   logic            push_inc;
   logic [CYW-1:0]  cyc_cnt;

   always_comb begin
      sel_cur = exp_sel[SELW-1:0];
      val_cur = exp_val[DW-1:0];
      for (int i = 0; i < NCHK; i++) begin
         if (ptr_q == PW'(i)) begin
            sel_cur = exp_sel[i*SELW +: SELW];
            val_cur = exp_val[i*DW +: DW];
         end
      end
   end

   assign hit = (dispDat == val_cur);

   // Current channel's bit is overwritten, so a later mismatch retracts an earlier match.
   always_comb begin
      match_upd = match_q;
      for (int i = 0; i < NCHK; i++) begin
         if (ptr_q == PW'(i)) match_upd[i] = hit;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      match_d     = match_q;
      fail_mask_d = fail_mask_q;
      last_push_d = last_push_q;
      run_clr     = 1'b0;
      cyc_inc     = 1'b0;
      push_inc    = 1'b0;
      case (state_q)
         RUN: begin
            match_d = match_upd;
            ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_ONE;
            cyc_inc = 1'b1;
            if (memwrite && (writedata != '0)) begin
               push_inc    = 1'b1;
               last_push_d = writedata;
            end
            if (&match_upd) begin
               state_d = PASS;
            end else if (cyc_cnt == CYC_LAST) begin
               state_d     = FAIL;
               fail_mask_d = ~match_upd;
            end
         end
         default: begin
            if (start) begin
               state_d     = RUN;
               ptr_d       = '0;
               match_d     = '0;
               fail_mask_d = '0;
               last_push_d = '0;
               run_clr     = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         match_q     <= '0;
         fail_mask_q <= '0;
         last_push_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         match_q     <= match_d;
         fail_mask_q <= fail_mask_d;
         last_push_q <= last_push_d;
      end
   end

   mon_sat_counter #(.CNTW(CYW)) u_cyc_cnt (
      .clk   (clk),
      .rst_n (reset),
      .clr   (run_clr),
      .inc   (cyc_inc),
      .q     (cyc_cnt)
   );

   mon_sat_counter #(.CNTW(CNTW)) u_push_cnt (
      .clk   (clk),
      .rst_n (reset),
      .clr   (run_clr),
      .inc   (push_inc),
      .q     (push_cnt)
   );

   // Forced to 0 while reset is held so the display port idles at register 0.
   assign dispSel   = !reset            ? '0
                    : (state_q == RUN)  ? sel_cur
                    :                     exp_sel[SELW-1:0];
   assign busy      = (state_q == RUN);
   assign done      = (state_q == PASS) || (state_q == FAIL);
   assign pass      = (state_q == PASS);
   assign fail_mask = fail_mask_q;
   assign last_push = last_push_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Scoreboard bench: stimulus queues expected verdicts, per-instance monitors check each rising done.
// Three instances cover NCHK=4 scanning/timeout, NCHK=1 fast pass, and a 2-bit saturating push count.
`timescale 1ns/1ps
module tb_mips_run_monitor;

   typedef struct {
      int          at_edge;
      logic        pass;
      logic [3:0]  fmask;
      logic [15:0] pcnt;
      logic [31:0] lpush;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];

   // Instance A: NCHK=4, TIMEOUT=20
   logic        start_a, memwrite_a;
   logic [31:0] wdata_a;
   logic [4:0]  dsel_a;
   logic [31:0] ddat_a;
   logic        busy_a, done_a, pass_a;
   logic [3:0]  fmask_a;
   logic [15:0] pcnt_a;
   logic [31:0] lpush_a;
   logic [31:0] rf_a [32];
   assign ddat_a = rf_a[dsel_a];

   mips_run_monitor #(.DW(32), .SELW(5), .NCHK(4), .TIMEOUT(20), .CNTW(16)) u_a (
      .clk(clk), .reset(reset), .start(start_a),
      .exp_sel({5'd9, 5'd7, 5'd5, 5'd3}),
      .exp_val({32'd400, 32'd300, 32'd200, 32'd100}),
      .memwrite(memwrite_a), .writedata(wdata_a),
      .dispSel(dsel_a), .dispDat(ddat_a),
      .busy(busy_a), .done(done_a), .pass(pass_a),
      .fail_mask(fmask_a), .push_cnt(pcnt_a), .last_push(lpush_a)
   );

   // Instance B: NCHK=1, always matching
   logic        start_b;
   logic [4:0]  dsel_b;
   logic        busy_b, done_b, pass_b;
   logic [0:0]  fmask_b;
   logic [15:0] pcnt_b;
   logic [31:0] lpush_b;

   mips_run_monitor #(.DW(32), .SELW(5), .NCHK(1), .TIMEOUT(1000), .CNTW(16)) u_b (
      .clk(clk), .reset(reset), .start(start_b),
      .exp_sel(5'd16), .exp_val(32'd24),
      .memwrite(1'b0), .writedata(32'd0),
      .dispSel(dsel_b), .dispDat(32'd24),
      .busy(busy_b), .done(done_b), .pass(pass_b),
      .fail_mask(fmask_b), .push_cnt(pcnt_b), .last_push(lpush_b)
   );

   // Instance C: NCHK=1, never matching, CNTW=2
   logic        start_c, memwrite_c;
   logic [31:0] wdata_c;
   logic [4:0]  dsel_c;
   logic        busy_c, done_c, pass_c;
   logic [0:0]  fmask_c;
   logic [1:0]  pcnt_c;
   logic [31:0] lpush_c;

   mips_run_monitor #(.DW(32), .SELW(5), .NCHK(1), .TIMEOUT(20), .CNTW(2)) u_c (
      .clk(clk), .reset(reset), .start(start_c),
      .exp_sel(5'd16), .exp_val(32'd24),
      .memwrite(memwrite_c), .writedata(wdata_c),
      .dispSel(dsel_c), .dispDat(32'd25),
      .busy(busy_c), .done(done_c), .pass(pass_c),
      .fail_mask(fmask_c), .push_cnt(pcnt_c), .last_push(lpush_c)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d (t=%0t)", nm, got, want, $time);
      end
   endtask

   task automatic cmp_rec(input string nm, input exp_t e, input logic p,
                          input logic [3:0] fm, input logic [15:0] pc, input logic [31:0] lp);
      chk({nm, "_done_edge"}, 64'(cyc), 64'(e.at_edge));
      chk({nm, "_pass"},      64'(p),   64'(e.pass));
      chk({nm, "_fail_mask"}, 64'(fm),  64'(e.fmask));
      chk({nm, "_push_cnt"},  64'(pc),  64'(e.pcnt));
      chk({nm, "_last_push"}, 64'(lp),  64'(e.lpush));
   endtask

   task automatic unexpected(input string nm);
      total++;
      bad++;
      $display("FAIL %s_unexpected_done got=done want=no_pending_verdict (t=%0t)", nm, $time);
   endtask

   logic done_a_p = 1'b0, done_b_p = 1'b0, done_c_p = 1'b0;

   always @(posedge clk) begin : mon_a
      exp_t e;
      #1;
      if (done_a && !done_a_p) begin
         if (q_a.size() == 0) unexpected("a");
         else begin
            e = q_a.pop_front();
            cmp_rec("a", e, pass_a, fmask_a, pcnt_a, lpush_a);
         end
      end
      done_a_p = done_a;
   end

   always @(posedge clk) begin : mon_b
      exp_t e;
      #1;
      if (done_b && !done_b_p) begin
         if (q_b.size() == 0) unexpected("b");
         else begin
            e = q_b.pop_front();
            cmp_rec("b", e, pass_b, 4'(fmask_b), pcnt_b, lpush_b);
         end
      end
      done_b_p = done_b;
   end

   always @(posedge clk) begin : mon_c
      exp_t e;
      #1;
      if (done_c && !done_c_p) begin
         if (q_c.size() == 0) unexpected("c");
         else begin
            e = q_c.pop_front();
            cmp_rec("c", e, pass_c, 4'(fmask_c), 16'(pcnt_c), lpush_c);
         end
      end
      done_c_p = done_c;
   end

   initial begin
      int s;
      reset = 1'b0;
      start_a = 1'b0; memwrite_a = 1'b0; wdata_a = '0;
      start_b = 1'b0;
      start_c = 1'b0; memwrite_c = 1'b0; wdata_c = '0;
      for (int i = 0; i < 32; i++) rf_a[i] = 32'hdead_0000 + 32'(i);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy_a), 64'd0);
      chk("rst_done", 64'(done_a), 64'd0);
      chk("rst_pass", 64'(pass_a), 64'd0);
      chk("rst_dispsel", 64'(dsel_a), 64'd0);
      chk("rst_push_cnt", 64'(pcnt_a), 64'd0);
      chk("rst_fail_mask", 64'(fmask_a), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_dispsel", 64'(dsel_a), 64'd3);

      // NCHK=1 match: verdict one edge after the sampling edge, then restart from PASS
      for (int r = 0; r < 2; r++) begin
         start_b = 1'b1;
         s = cyc + 1;
         q_b.push_back('{s + 1, 1'b1, 4'd0, 16'd0, 32'd0});
         @(negedge clk);
         start_b = 1'b0;
         chk("b_busy_in_run", 64'(busy_b), 64'd1);
         chk("b_dispsel_run", 64'(dsel_b), 64'd16);
         repeat (4) @(negedge clk);
         chk("b_done_held", 64'(done_b), 64'd1);
      end

      // CNTW=2: five pushes saturate at 3, timeout after 20 RUN cycles
      start_c = 1'b1;
      s = cyc + 1;
      q_c.push_back('{s + 20, 1'b0, 4'd1, 16'd3, 32'd5});
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start_c = 1'b0;
         memwrite_c = 1'b1;
         wdata_c = 32'(k);
      end
      @(negedge clk);
      memwrite_c = 1'b0;
      chk("c_busy_in_run", 64'(busy_c), 64'd1);
      chk("c_dispsel_run", 64'(dsel_c), 64'd16);
      repeat (20) @(negedge clk);

      // A: ch2 mismatches until RUN cycle 10, pass on cycle 11; pre-start push ignored
      rf_a[3] = 32'd100; rf_a[5] = 32'd200; rf_a[7] = 32'd999; rf_a[9] = 32'd400;
      memwrite_a = 1'b1; wdata_a = 32'd9;
      @(negedge clk);
      memwrite_a = 1'b0;
      start_a = 1'b1;
      s = cyc + 1;
      q_a.push_back('{s + 11, 1'b1, 4'd0, 16'd0, 32'd0});
      @(negedge clk);
      start_a = 1'b0;
      repeat (9) @(negedge clk);
      chk("a_dispsel_cycle10", 64'(dsel_a), 64'd5);
      rf_a[7] = 32'd300;
      repeat (6) @(negedge clk);
      chk("a_pass_held", 64'(pass_a), 64'd1);

      // A: ch1 never matches -> timeout; pushes 5,0,7; start during RUN ignored
      memwrite_a = 1'b1; wdata_a = 32'd11;
      @(negedge clk);
      memwrite_a = 1'b0;
      rf_a[5] = 32'd0;
      start_a = 1'b1;
      s = cyc + 1;
      q_a.push_back('{s + 20, 1'b0, 4'b0010, 16'd2, 32'd7});
      @(negedge clk);
      start_a = 1'b0;
      @(negedge clk); memwrite_a = 1'b1; wdata_a = 32'd5;
      @(negedge clk); wdata_a = 32'd0;
      @(negedge clk); wdata_a = 32'd7;
      @(negedge clk); memwrite_a = 1'b0; wdata_a = 32'd0;
      repeat (3) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (16) @(negedge clk);
      chk("a_fail_no_pass", 64'(pass_a), 64'd0);

      // A: asynchronous reset mid-RUN, then a clean rerun
      rf_a[5] = 32'd200;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      memwrite_a = 1'b1; wdata_a = 32'd33;
      @(negedge clk);
      memwrite_a = 1'b0;
      chk("a_precut_push_cnt", 64'(pcnt_a), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("arst_busy", 64'(busy_a), 64'd0);
      chk("arst_done", 64'(done_a), 64'd0);
      chk("arst_push_cnt", 64'(pcnt_a), 64'd0);
      chk("arst_last_push", 64'(lpush_a), 64'd0);
      chk("arst_dispsel", 64'(dsel_a), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", 64'(busy_a), 64'd0);
      start_a = 1'b1;
      s = cyc + 1;
      q_a.push_back('{s + 4, 1'b1, 4'd0, 16'd0, 32'd0});
      @(negedge clk);
      start_a = 1'b0;
      repeat (8) @(negedge clk);

      chk("a_verdicts_left", 64'(q_a.size()), 64'd0);
      chk("b_verdicts_left", 64'(q_b.size()), 64'd0);
      chk("c_verdicts_left", 64'(q_c.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
